// File: rtl/output_interface_pkg.sv
// output_interface_pkg: shared widths, IEEE-754 constants, FSM encoding and
// the special-value packer used by the result packer and its rounder.
package output_interface_pkg;
    localparam int REG_SIZE = 64;
    localparam int MAN_W    = 64;
    localparam int EXP_W    = 13;
    localparam int OP_BITS  = 2;
    localparam int S_MODE   = 1;
    localparam int BE_W     = EXP_W + 2;
    localparam int S_BIAS   = 127;
    localparam int D_BIAS   = 1023;
    localparam int S_FRAC   = 23;
    localparam int D_FRAC   = 52;
    localparam int S_MAXE   = 255;
    localparam int D_MAXE   = 2047;
    localparam int S_SIGN   = 31;
    localparam int D_SIGN   = 63;
    localparam int S_EXP    = 23;
    localparam int D_EXP    = 52;
    localparam logic [REG_SIZE-1:0] S_QNAN = 64'h0000_0000_7FC0_0000;
    localparam logic [REG_SIZE-1:0] D_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic signed [BE_W-1:0] BE_ONE   = BE_W'(1);
    localparam logic signed [BE_W-1:0] S_TINY   = BE_W'(-(S_FRAC + 2));
    localparam logic signed [BE_W-1:0] D_TINY   = BE_W'(-(D_FRAC + 2));
    localparam logic signed [BE_W-1:0] S_MAX_BE = BE_W'(S_MAXE);
    localparam logic signed [BE_W-1:0] D_MAX_BE = BE_W'(D_MAXE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_DENORM = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // NaN wins over inf; with neither set the word is a signed zero.
    function automatic logic [REG_SIZE-1:0] pack_special(input logic single, input logic sign,
                                                         input logic nan, input logic inf);
        logic [REG_SIZE-1:0] w;
        w = '0;
        if (nan) begin
            w = single ? S_QNAN : D_QNAN;
        end else if (single) begin
            w[S_SIGN] = sign;
            if (inf) w[S_SIGN-1:S_EXP] = '1;
        end else begin
            w[D_SIGN] = sign;
            if (inf) w[D_SIGN-1:D_EXP] = '1;
        end
        return w;
    endfunction
endpackage

// File: rtl/output_interface_round_nearest_even.sv
// round_nearest_even: round a left-justified mantissa to nearest-even and pack
// the IEEE word, saturating to infinity when the exponent overflows.
module round_nearest_even
    import output_interface_pkg::*;
(
    input  logic [MAN_W-1:0]       man_i,
    input  logic                   sticky_i,
    input  logic                   single_i,
    input  logic                   sign_i,
    input  logic signed [BE_W-1:0] be_i,
    output logic [REG_SIZE-1:0]    word_o,
    output logic                   inexact_o,
    output logic                   overflow_o
);
    localparam int SL = MAN_W - 1 - S_FRAC;
    localparam int DL = MAN_W - 1 - D_FRAC;
    localparam int SW = S_FRAC + 2;
    localparam int DW = D_FRAC + 2;
    logic g_s, st_s, g_d, st_d, carry, msb;
    logic [SW-1:0] sum_s;
    logic [DW-1:0] sum_d;
    logic signed [BE_W-1:0] be_r;
    // A carry out of the kept bits leaves 100..0, which is sum>>1 with a zero fraction.
    always_comb begin
        g_s        = man_i[SL-1];
        st_s       = |man_i[SL-2:0] | sticky_i;
        g_d        = man_i[DL-1];
        st_d       = |man_i[DL-2:0] | sticky_i;
        sum_s      = {1'b0, man_i[MAN_W-1:SL]} + SW'(g_s & (st_s | man_i[SL]));
        sum_d      = {1'b0, man_i[MAN_W-1:DL]} + DW'(g_d & (st_d | man_i[DL]));
        carry      = single_i ? sum_s[SW-1] : sum_d[DW-1];
        msb        = carry | (single_i ? sum_s[S_FRAC] : sum_d[D_FRAC]);
        be_r       = be_i + BE_W'(carry);
        overflow_o = be_r >= (single_i ? S_MAX_BE : D_MAX_BE);
        inexact_o  = overflow_o | (single_i ? g_s | st_s : g_d | st_d);
        word_o     = overflow_o ? pack_special(single_i, sign_i, 1'b0, 1'b1)
                   : single_i   ? {32'b0, sign_i, msb ? be_r[7:0] : 8'd0, sum_s[S_FRAC-1:0]}
                   :              {sign_i, msb ? be_r[10:0] : 11'd0, sum_d[D_FRAC-1:0]};
    end
endmodule

// File: rtl/output_interface.sv
// output_interface: iterative normalize / denormalize / round-to-nearest-even
// packer turning an integer result and exponent into an IEEE single or double.
module output_interface
    import output_interface_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [OP_BITS-1:0]      operation,
    input  logic [MAN_W-1:0]        resMan,
    input  logic signed [EXP_W-1:0] resExp,
    input  logic                    resSign,
    input  logic                    resNan,
    input  logic                    resInf,
    input  logic                    resZero,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [REG_SIZE-1:0]     result,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    inexact
);
    state_t state_q, state_d;
    logic single_q, single_d, sign_q, sign_d, sticky_q, sticky_d, tiny_q, tiny_d;
    logic ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
    logic [MAN_W-1:0] man_q, man_d;
    logic signed [BE_W-1:0] be_q, be_d, be_acc, tiny_lim;
    logic [REG_SIZE-1:0] res_q, res_d, rnd_word;
    logic rnd_inexact, rnd_ovf, special, unused_op;

    assign unused_op = operation[0];
    assign special   = resNan | resInf | resZero | (resMan == '0);
    assign be_acc    = {{(BE_W-EXP_W){resExp[EXP_W-1]}}, resExp} + BE_W'(MAN_W - 1)
                     + (operation[S_MODE] ? BE_W'(S_BIAS) : BE_W'(D_BIAS));
    assign tiny_lim  = single_q ? S_TINY : D_TINY;

    round_nearest_even u_round (
        .man_i      (man_q),
        .sticky_i   (sticky_q),
        .single_i   (single_q),
        .sign_i     (sign_q),
        .be_i       (be_q),
        .word_o     (rnd_word),
        .inexact_o  (rnd_inexact),
        .overflow_o (rnd_ovf)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            tiny_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
            man_q    <= '0;
            be_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            tiny_q   <= tiny_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
            man_q    <= man_d;
            be_q     <= be_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        tiny_d   = tiny_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        man_d    = man_q;
        be_d     = be_q;
        res_d    = res_q;
        case (state_q)
            ST_IDLE: if (inValid) begin
                single_d = operation[S_MODE];
                sign_d   = resSign;
                man_d    = resMan;
                be_d     = be_acc;
                sticky_d = 1'b0;
                tiny_d   = 1'b0;
                ovf_d    = 1'b0;
                unf_d    = 1'b0;
                inx_d    = 1'b0;
                res_d    = pack_special(operation[S_MODE], resSign, resNan, resInf);
                state_d  = special ? ST_DONE : ST_NORM;
            end
            ST_NORM: if (!man_q[MAN_W-1]) begin
                man_d = man_q << 1;
                be_d  = be_q - BE_ONE;
            end else if (be_q < BE_ONE) begin
                tiny_d  = 1'b1;
                state_d = ST_DENORM;
            end else begin
                state_d = ST_ROUND;
            end
            // Far below the subnormal range everything collapses into sticky at once.
            ST_DENORM: if (be_q < tiny_lim) begin
                man_d    = '0;
                sticky_d = 1'b1;
                be_d     = BE_ONE;
                state_d  = ST_ROUND;
            end else begin
                man_d    = man_q >> 1;
                sticky_d = sticky_q | man_q[0];
                be_d     = be_q + BE_ONE;
                state_d  = (be_q == '0) ? ST_ROUND : ST_DENORM;
            end
            ST_ROUND: begin
                res_d   = rnd_word;
                ovf_d   = rnd_ovf;
                inx_d   = rnd_inexact;
                unf_d   = tiny_q & rnd_inexact;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = outReady ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inReady   = rstN && (state_q == ST_IDLE);
        outValid  = state_q == ST_DONE;
        result    = res_q;
        overflow  = ovf_q;
        underflow = unf_q;
        inexact   = inx_q;
    end
endmodule

// File: tb/tb_output_interface.sv
// tb_output_interface: table vectors, randomized beats against an exact-value
// rounding model, plus backpressure and asynchronous-reset sequences.
module tb_output_interface;
    logic        clk = 1'b0, rstN = 1'b0, inValid = 1'b0, outReady = 1'b1;
    logic        inReady, outValid, overflow, underflow, inexact;
    logic [1:0]  operation = 2'b00;
    logic [63:0] resMan = '0, result;
    logic [12:0] resExp = '0;
    logic        resSign = 1'b0, resNan = 1'b0, resInf = 1'b0, resZero = 1'b0;
    int tests = 0, fails = 0;

    output_interface dut (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .operation(operation),
        .resMan(resMan), .resExp(resExp), .resSign(resSign), .resNan(resNan), .resInf(resInf),
        .resZero(resZero), .outValid(outValid), .outReady(outReady), .result(result),
        .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        single, sign, nan, inf, zero;
        logic [63:0] man;
        int          rexp;
        logic [63:0] w;
        logic [2:0]  fl;
        int          lat;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Exact value man*2^rexp rounded to nearest-even at the target lsb weight.
    function automatic void model(input logic single, sign, nan, inf, zero, input logic [63:0] man,
                                  input int rexp, output logic [63:0] w, output logic [2:0] fl,
                                  output int lat);
        int f, bias, maxe, p, eb, s, e;
        logic [63:0] q, fr;
        logic g, st;
        f = single ? 23 : 52;
        bias = single ? 127 : 1023;
        maxe = single ? 255 : 2047;
        fl = 3'b000;
        lat = 1;
        if (nan) begin
            w = single ? 64'h7FC00000 : 64'h7FF8000000000000;
            return;
        end
        if (inf) begin
            w = single ? {32'b0, sign, 8'hFF, 23'b0} : {sign, 11'h7FF, 52'b0};
            return;
        end
        if (zero || man == 0) begin
            w = single ? {32'b0, sign, 31'b0} : {sign, 63'b0};
            return;
        end
        p = 63;
        while (!man[p]) p--;
        eb = p + rexp + bias;
        s = (eb >= 1) ? p - f : p - f + 1 - eb;
        lat = 3 + (63 - p) + ((eb >= 1) ? 0 : (eb < -(f + 2)) ? 1 : 1 - eb);
        if (s <= 0) begin
            q = man << (-s); g = 1'b0; st = 1'b0;
        end else if (s > 64) begin
            q = '0; g = 1'b0; st = 1'b1;
        end else begin
            q = (s == 64) ? 64'd0 : man >> s;
            g = man[s-1];
            st = (man & ((64'd1 << (s - 1)) - 64'd1)) != 0;
        end
        q = q + {63'b0, g & (st | q[0])};
        e = (eb >= 1) ? eb : 0;
        if (q[f+1]) begin q = q >> 1; e++; end
        if (eb < 1 && q[f]) e = 1;
        fr = q & ((64'd1 << f) - 64'd1);
        if (e >= maxe) begin
            fl = 3'b101;
            w = single ? {32'b0, sign, 8'hFF, 23'b0} : {sign, 11'h7FF, 52'b0};
        end else begin
            fl = {1'b0, (eb < 1) && (g | st), g | st};
            w = single ? {32'b0, sign, 8'(e), fr[22:0]} : {sign, 11'(e), fr[51:0]};
        end
    endfunction

    task automatic run(input logic single, sign, nan, inf, zero, input logic [63:0] man,
                       input int rexp, output logic [63:0] w, output logic [2:0] fl, output int lat);
        @(negedge clk);
        operation = {single, 1'b0};
        resSign = sign; resNan = nan; resInf = inf; resZero = zero;
        resMan = man; resExp = 13'(rexp); inValid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        inValid = 1'b0;
        resMan = {$urandom, $urandom}; resExp = 13'($urandom); operation = 2'($urandom);
        resNan = 1'($urandom); resInf = 1'($urandom); resZero = 1'($urandom); resSign = 1'($urandom);
        while (!outValid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        w = result;
        fl = {overflow, underflow, inexact};
        if (outValid && outReady) begin
            @(posedge clk);
            #1 chk("valid_drop", 64'(outValid), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] w, ew, man;
        logic [2:0] fl, efl;
        int lat, elat, p, eb, rexp, k, seen;
        logic single, sign, nan, inf, zero;
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] w, ew, man;
        logic [2:0] fl, efl;
        int lat, elat, p, eb, rexp, k, seen;
        logic single, sign, nan, inf, zero;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, -63,  64'h3F800000, 3'b000, 3};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h3, 0,                    64'h40400000, 3'b000, 65};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFFFF8000000000, -63,  64'h40000000, 3'b001, 3};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, 961,  64'h7FF0000000000000, 3'b101, 3};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, -212, 64'h00000001, 3'b000, 26};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h5, 0,                    64'h7FC00000, 3'b000, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h5, 0,                    64'h7FF8000000000000, 3'b000, 1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h5, 0,                    64'hFF800000, 3'b000, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd123, 0,                  64'h8000000000000000, 3'b000, 1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 5,                    64'h80000000, 3'b000, 1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000000, -216, 64'h00000000, 3'b011, 4};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000000000000400, -63,  64'h3FF0000000000000, 3'b001, 3};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFFFF0000000000, -190, 64'h00800000, 3'b011, 4};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFFFF0000000000, 64,   64'h7F7FFFFF, 3'b000, 3};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFFFF8000000000, 64,   64'h7F800000, 3'b101, 3};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h7, 0,                    64'h7FC00000, 3'b000, 1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h7, 0,                    64'h7FF0000000000000, 3'b000, 1};

        #3;
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_inReady", 64'(inReady), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1 chk("idle_inReady", 64'(inReady), 64'd1);

        foreach (tbl[i]) begin
            run(tbl[i].single, tbl[i].sign, tbl[i].nan, tbl[i].inf, tbl[i].zero, tbl[i].man,
                tbl[i].rexp, w, fl, lat);
            chk($sformatf("vec%0d_word", i), w, tbl[i].w);
            chk($sformatf("vec%0d_flags", i), 64'(fl), 64'(tbl[i].fl));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
        end

        for (int n = 0; n < 300; n++) begin
            single = 1'($urandom);
            sign = 1'($urandom);
            k = $urandom_range(0, 19);
            nan = (k == 0); inf = (k == 1); zero = (k == 2);
            man = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (k == 4 || k == 5) man = man & ~64'hFFFF;
            if (man == 0) man = 64'd1;
            if (k == 3) man = 64'd0;
            p = 63;
            while (p > 0 && !man[p]) p--;
            eb = single ? int'($urandom_range(0, 300)) - 40 : int'($urandom_range(0, 2130)) - 80;
            rexp = eb - p - (single ? 127 : 1023);
            model(single, sign, nan, inf, zero, man, rexp, ew, efl, elat);
            run(single, sign, nan, inf, zero, man, rexp, w, fl, lat);
            chk($sformatf("rnd%0d_word man=%h exp=%0d s=%0d", n, man, rexp, single), w, ew);
            chk($sformatf("rnd%0d_flags", n), 64'(fl), 64'(efl));
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(elat));
        end

        // Backpressure: result held, no accept while DONE even with inValid high.
        outReady = 1'b0;
        run(tbl[2].single, tbl[2].sign, tbl[2].nan, tbl[2].inf, tbl[2].zero, tbl[2].man,
            tbl[2].rexp, w, fl, lat);
        inValid = 1'b1; resNan = 1'b1; operation = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_result", c), result, tbl[2].w);
            chk($sformatf("hold%0d_inReady", c), 64'(inReady), 64'd0);
            chk($sformatf("hold%0d_outValid", c), 64'(outValid), 64'd1);
        end
        inValid = 1'b0; resNan = 1'b0; outReady = 1'b1;
        @(posedge clk);
        #1 chk("hold_release", 64'(outValid), 64'd0);

        // Asynchronous reset in the middle of a long NORM run.
        @(negedge clk);
        operation = 2'b10; resMan = 64'd1; resExp = '0; inValid = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstN = 1'b0;
        #1 chk("norm_rst_outValid", 64'(outValid), 64'd0);
        chk("norm_rst_result", result, 64'd0);
        #1 rstN = 1'b1;
        #1 chk("norm_rst_inReady", 64'(inReady), 64'd1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            seen |= int'(outValid);
        end
        chk("norm_rst_no_resume", 64'(seen), 64'd0);

        // Asynchronous reset while a result is waiting in DONE.
        outReady = 1'b0;
        run(tbl[3].single, tbl[3].sign, tbl[3].nan, tbl[3].inf, tbl[3].zero, tbl[3].man,
            tbl[3].rexp, w, fl, lat);
        chk("done_rst_pre", 64'(outValid), 64'd1);
        #1 rstN = 1'b0;
        #1 chk("done_rst_outValid", 64'(outValid), 64'd0);
        chk("done_rst_result", result, 64'd0);
        chk("done_rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
        #1 rstN = 1'b1;
        outReady = 1'b1;
        run(tbl[0].single, tbl[0].sign, tbl[0].nan, tbl[0].inf, tbl[0].zero, tbl[0].man,
            tbl[0].rexp, w, fl, lat);
        chk("post_rst_word", w, tbl[0].w);
        chk("post_rst_lat", 64'(lat), 64'(tbl[0].lat));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/output_interface.md
# output_interface

Result packer at the back end of the FPU divide/sqrt datapath. It takes an unnormalized integer result, a two's-complement exponent, a sign and special-case flags. It normalizes the result iteratively, handles subnormals, rounds to nearest-even and packs an IEEE-754 single or double word. It is the encoding counterpart of the input decode stage and uses the same `operation[1]` mode convention, with a valid/ready handshake on both sides.

## Interface
- `REG_SIZE`, 64, packed result width.
- `MAN_W`, 64, width of the incoming integer result.
- `EXP_W`, 13, width of the incoming signed exponent.
- `OP_BITS`, 2, operation width; bit 1 selects single (`S_MODE`) or double.
- `clk`  in  1  single clock, rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  input beat valid.
- `inReady`  out  1  block can accept a beat; high only in IDLE.
- `operation`  in  OP_BITS  mode select; sampled at accept.
- `resMan`  in  MAN_W  unsigned integer result; value is resMan × 2^resExp.
- `resExp`  in  EXP_W  signed exponent of the resMan LSB.
- `resSign`, `resNan`, `resInf`, `resZero`  in  1 each  sign and special-result flags; priority is nan > inf > zero.
- `outValid`  out  1  packed result valid.
- `outReady`  in  1  consumer accepts the result.
- `result`  out  REG_SIZE  IEEE word; single mode drives bits [31:0] and forces upper 32 bits to 0.
- `overflow`, `underflow`, `inexact`  out  1 each  exception flags; valid with `outValid`.

## Operation
- States: IDLE, NORM, DENORM, ROUND, DONE. Reset forces IDLE and all outputs to 0 (`inReady`=1 once out of reset).
- Accept happens when IDLE & `inValid`. The block registers the mode, sign and `resMan`, and sets the biased exponent to be = resExp + (MAN_W−1) + bias. bias is 127 (single) or 1023 (double). The internal `be` is signed, EXP_W+2 bits wide. The sticky register is cleared.
- Special inputs go from accept straight to DONE:
  - nan → canonical quiet NaN 0x7FC00000 or 0x7FF8000000000000, sign 0.
  - inf → ±inf.
  - zero, or resMan==0 → ±0.
  - All flags stay 0 for special results.
- NORM:
  - If man[63]==0: shift man left 1 and decrement be.
  - Else if be ≤ 0: go to DENORM.
  - Else: go to ROUND.
- DENORM:
  - If be < −(F+2): man=0, sticky=1, be=1 in one cycle.
  - Otherwise each cycle shifts man right 1 (the shifted-out bit ORs into sticky) and increments be, until be==1. Then go to ROUND.
  - F is 23 (single) or 52 (double). The tiny flag is set on entry.
- ROUND (one cycle), with kept = man[63:63−F]:
  - lsb = man[63−F], guard = man[62−F], st = |man[61−F:0] | sticky.
  - Round up iff guard & (st | lsb). inexact = guard | st.
  - If the kept-bit increment carries out: kept = 1000…0 and be increments.
  - Exp field = be if kept MSB is 1, else 0 (subnormal; rounding into bit F yields exp field 1 naturally).
  - If be ≥ 255/2047: result = ±inf, overflow=1, inexact=1.
  - underflow = tiny & inexact.
  - Register result and flags, then go to DONE.
- DONE: `outValid`=1. Result and flags are held stable until `outReady`; on that handshake go to IDLE. No new beat is accepted in the same cycle (`inReady` is low in DONE).

## Timing
- Latency is counted in clock edges from the accept edge to `outValid` high.
  - Special inputs: 1.
  - Normalized input (man[63]=1): 3.
  - Otherwise 3 + left shifts + denorm shifts.
- Worst case is bounded by MAN_W + F + 5 edges.
- `outValid` deasserts the cycle after the handshake edge.
- Asynchronous reset mid-operation aborts immediately: state IDLE, `outValid`=0, result, flags and internals cleared, `inReady`=1 after release.
- Inputs are don't-care except on the accept edge.

## Structure
- Shared constants go in defs/header.h:
  - `S_MODE`, OP_BITS, MODE_S/MODE_D sign and exponent bit positions.
  - Biases 127/1023, fraction widths 23/52, max exponents 255/2047.
  - Canonical NaN patterns.
  - State encodings (3-bit).
- One natural sub-module, `round_nearest_even`: combinational. It takes the 64-bit man, sticky, mode and be, and returns the packed fields, carry and inexact. The FSM and shift registers stay in `output_interface`.

## Test plan
- Single, resMan=0x8000000000000000, resExp=−63 → `result`=0x3F800000, latency 3, all flags 0.
- Single, resMan=3, resExp=0 → 0x40400000 after 62 NORM shifts (latency 65), exact.
- Single, resMan=0xFFFFFF8000000000, resExp=−63 (tie, odd lsb) → 0x40000000 via carry-out, inexact=1.
- Double, resMan=0x8000000000000000, resExp=961 → 0x7FF0000000000000, overflow=1, inexact=1.
- Single, resMan=0x8000000000000000, resExp=−212 → 0x00000001 after 23 DENORM shifts (latency 26), underflow=0. resNan=1 → 0x7FC00000 at latency 1.
- Hold `outReady` low 5 cycles in DONE → `result` stable, `inReady`=0. Assert `rstN`=0 mid-NORM → `outValid`=0 and IDLE immediately.
